// File: rtl/lfsr3b_pkg.sv
// Shared definitions for the 3-bit LFSR pattern generator and checker pair.
package lfsr3b_pkg;

   localparam logic [2:0] LFSR3B_SEED   = 3'b100;
   localparam int         LFSR3B_PERIOD = 7;

   typedef enum logic [0:0] {
      S_SEARCH = 1'b0,
      S_LOCKED = 1'b1
   } lfsr3b_state_e;

endpackage

// File: rtl/lfsr3b_next.sv
// Combinational next-state function of the 3-bit LFSR.
// The generator and checker both use this module, so they share one polynomial.
module lfsr3b_next (
   input  logic [2:0] cur,
   output logic [2:0] nxt
);

   assign nxt = {cur[2] ^ cur[0], cur[2], cur[1]};

endmodule

// File: rtl/lfsr3b_checker.sv
// Self-synchronising receive-side checker for the 3-bit LFSR pattern stream.
// Optional all-zero lockup detection on STUCK is enabled by defining LFSR3B_CHK_STUCK_EN.
module lfsr3b_checker
   import lfsr3b_pkg::*;
#(
   parameter int LOCK_CNT = 3,
   parameter int LOSS_CNT = 2,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       in,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic             stuck
);

   localparam logic [0:0] ST_SEARCH = S_SEARCH;
   localparam logic [0:0] ST_LOCKED = S_LOCKED;
   localparam logic [2:0] LOCK_N    = 3'(LOCK_CNT);
   localparam logic [2:0] LOSS_N    = 3'(LOSS_CNT);

   logic [0:0]       state_q;
   logic [2:0]       ref_q;
   logic [2:0]       exp_word;
   logic             have_q;
   logic [2:0]       good_q;
   logic [2:0]       miss_q;
   logic             err_q;
   logic [ERR_W-1:0] err_cnt_q;
   logic             match;

   lfsr3b_next u_next (
      .cur (ref_q),
      .nxt (exp_word)
   );

   // The all-zero word is the LFSR lockup state, so it can never count as a match.
   assign match = en & have_q & (in == exp_word) & (in != 3'b000);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_SEARCH;
         ref_q     <= 3'b000;
         have_q    <= 1'b0;
         good_q    <= 3'd0;
         miss_q    <= 3'd0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         err_q <= 1'b0;
         if (en) begin
            if (state_q == ST_SEARCH) begin
               ref_q  <= in;
               have_q <= 1'b1;
               if (match) begin
                  if (good_q + 3'd1 == LOCK_N) begin
                     state_q <= ST_LOCKED;
                     good_q  <= 3'd0;
                     miss_q  <= 3'd0;
                  end else begin
                     good_q <= good_q + 3'd1;
                  end
               end else begin
                  good_q <= 3'd0;
               end
            end else begin
               // Flywheel on our own prediction; the received word only matters on lock loss.
               ref_q <= exp_word;
               if (match) begin
                  miss_q <= 3'd0;
               end else begin
                  err_q <= 1'b1;
                  if (err_cnt_q != '1) begin
                     err_cnt_q <= err_cnt_q + ERR_W'(1);
                  end
                  if (miss_q + 3'd1 == LOSS_N) begin
                     state_q <= ST_SEARCH;
                     ref_q   <= in;
                     have_q  <= 1'b1;
                     good_q  <= 3'd0;
                     miss_q  <= 3'd0;
                  end else begin
                     miss_q <= miss_q + 3'd1;
                  end
               end
            end
         end
      end
   end

   assign locked  = (state_q == ST_LOCKED);
   assign err     = err_q;
   assign err_cnt = err_cnt_q;

`ifdef LFSR3B_CHK_STUCK_EN
   logic stuck_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stuck_q <= 1'b0;
      end else if (en) begin
         stuck_q <= (in == 3'b000);
      end
   end

   assign stuck = stuck_q;
`else
   assign stuck = 1'b0;
`endif

endmodule

// File: doc/lfsr3b_checker.md
# lfsr3b_checker

Receive-side companion to the 3-bit LFSR pattern generator (seed 3'b100, next = {s[2]^s[0], s[2], s[1]}, period 7). It takes the generator's enabled word stream, self-synchronises to it, declares lock after a run of consecutive correct words, and then flywheels on its own prediction. While locked it flags and counts mismatches, and it drops lock after a run of consecutive misses. It sits at the far end of a link or datapath under test, as the pattern sink for built-in self-test.

## Interface
- LOCK_CNT, 3, consecutive matches in SEARCH required to lock (1..7)
- LOSS_CNT, 2, consecutive mismatches in LOCKED required to drop lock (1..7)
- ERR_W, 8, width of saturating error counter
- CLK  input  1  clock, rising edge
- RSTN  input  1  reset, asynchronous, active-low
- EN  input  1  sample qualifier; IN is evaluated only when EN=1
- IN  input  3  received LFSR word
- LOCKED  output  1  registered; 1 while in LOCKED state
- ERR  output  1  registered one-cycle pulse per mismatch while LOCKED
- ERR_CNT  output  ERR_W  saturating count of mismatches while LOCKED
- STUCK  output  1  all-zero lockup indicator (0 unless LFSR3B_CHK_STUCK_EN)

## Operation
- Internal state: REF[2:0] (previous or predicted word), HAVE (REF valid), GOOD counter, MISS counter, FSM {SEARCH, LOCKED}.
- Definitions: exp = next(REF); match = EN & HAVE & (IN == exp) & (IN != 3'b000). An IN of 3'b000 is always a mismatch.
- EN=0: no state changes; ERR returns to 0.
- SEARCH, EN=1: REF<=IN and HAVE<=1. On match, GOOD++; when GOOD reaches LOCK_CNT, go to LOCKED with MISS=0. On a non-match, GOOD<=0. The first sample after reset only loads REF and never counts.
- LOCKED, EN=1: REF<=exp (flywheel; IN is not used to resync). On match, MISS<=0. On mismatch, ERR<=1, ERR_CNT++ (saturating at all-ones), and MISS++. When MISS reaches LOSS_CNT, go to SEARCH with REF<=IN, HAVE<=1, GOOD<=0.
- ERR_CNT is cleared only by reset, and it holds across lock loss and relock.
- Mismatches in SEARCH never raise ERR and never increment ERR_CNT.

## Timing
- Reset values: LOCKED=0, ERR=0, ERR_CNT=0, STUCK=0, state SEARCH, HAVE=0, REF=3'b000, GOOD=0, MISS=0.
- All outputs are registered.
- Lock: LOCKED rises on the clock edge that samples the LOCK_CNT-th consecutive match.
- ERR and ERR_CNT update on the edge that samples the mismatching word, so they are visible one cycle after that sample is presented.
- Loss of lock: LOCKED falls on the edge that samples the LOSS_CNT-th consecutive miss. ERR is also asserted for that sample.
- Simultaneous events: lock loss and an ERR pulse on the same sample are both reported. Saturation does not suppress ERR.
- Reset asserted mid-operation: all state returns to reset values asynchronously. After release, the checker needs 1 + LOCK_CNT enabled samples before it can lock.

## Configuration
- LFSR3B_CHK_STUCK_EN defined: STUCK<=1 on any enabled sample where IN==3'b000, and STUCK<=0 on any enabled nonzero sample. The update is registered and independent of FSM state.
- LFSR3B_CHK_STUCK_EN undefined: STUCK is tied to 0 and there is no detection logic. The rule that 3'b000 is always a mismatch still applies.

## Structure
- Shared package lfsr3b_pkg: seed constant LFSR3B_SEED=3'b100, state typedef {SEARCH, LOCKED}, period constant LFSR3B_PERIOD=7.
- Sub-module lfsr3b_next: combinational 3-bit next-state function. The generator side uses the same module so both ends share one polynomial definition.

## Test plan
- Lock: reset, then EN=1 with IN sequence 100,110,111,011 (LOCK_CNT=3) -> LOCKED=1 after the 011 edge; ERR=0 and ERR_CNT=0 throughout.
- Single error: while locked with expected 101, drive 001 and then 010 -> one ERR pulse, ERR_CNT=1, LOCKED stays 1, and 010 is accepted with no error.
- Loss and relock: while locked, drive two wrong words (LOSS_CNT=2) -> LOCKED=0 after the second. Then feed 001,100,110,111 -> relock, with ERR_CNT unchanged at 2.
- EN gaps: insert idle cycles with EN=0 and random IN between correct words -> no state change, lock reached exactly as with a contiguous stream.
- Saturation: ERR_W=2, LOSS_CNT=7, five single-word errors while locked -> ERR_CNT stays 3 and ERR pulses five times.
- Stuck/reset: with LFSR3B_CHK_STUCK_EN, drive 000,000 -> STUCK=1, no lock, and no GOOD increment. Then assert RSTN=0 mid-stream -> all outputs return to 0 immediately.
